l2_trace_sequencer: RTL
=======================

// Module: l2_trace_sequencer
// PURPOSE
//  Upstream feeder for the L2 cache. Buffers decoded trace records (cmd, addr) and issues them in order
//  to the cache's L1-side request port or snoop-side request port with valid/ready handshakes.
//  Executes the clear (8) and print (9) trace commands as statistics strobes after in-flight work drains.
//  Drops illegal commands and counts them.
// PARAMETERS
//  addressSize  32  trace/request address width
//  fifoDepth    8   record buffer depth; power of 2, >= 2
//  cntWidth     32  width of issue/error counters
// PORTS
//  clk           in   1            system clock, rising edge
//  reset_n       in   1            async active-low reset
//  trace_valid   in   1            trace record offered
//  trace_ready   out  1            buffer can accept (= !fifo_full)
//  trace_cmd     in   4            trace command code
//  trace_addr    in   addressSize  trace address
//  l1_valid      out  1            L1 request valid (cmds 0,1,2)
//  l1_ready      in   1            cache accepts L1 request
//  l1_op         out  2            0 rd data, 1 wr data, 2 rd instr
//  l1_addr       out  addressSize  L1 request address
//  snp_valid     out  1            snoop request valid (cmds 3..6)
//  snp_ready     in   1            cache accepts snoop request
//  snp_op        out  2            cmd-3: 0 inval, 1 read, 2 write, 3 RWIM
//  snp_addr      out  addressSize  snoop request address
//  busy          in   1            cache has a transaction in progress
//  clear_stats   out  1            one-cycle strobe, trace cmd 8
//  print_stats   out  1            one-cycle strobe, trace cmd 9
//  l1_count      out  cntWidth     accepted L1 requests
//  snp_count     out  cntWidth     accepted snoop requests
//  err_count     out  cntWidth     dropped illegal commands (7, 10..15)
// BEHAVIOUR
//  Reset (async, reset_n=0): FIFO empty, state IDLE, all valids/strobes 0, ops/addrs 0, counters 0.
//  FIFO: write when trace_valid&&trace_ready; pop only when FSM leaves IDLE with a record (registered
//   into output regs). Simultaneous push+pop when full: push refused (trace_ready=0 that cycle).
//   Pointers wrap modulo fifoDepth; extra bit distinguishes full from empty.
//  FSM states: IDLE, ISSUE_L1, ISSUE_SNP, DRAIN, STROBE.
//   IDLE, FIFO non-empty: pop head; cmd 0..2 -> ISSUE_L1; 3..6 -> ISSUE_SNP; 8/9 -> DRAIN;
//    illegal -> err_count+1, stay IDLE (one record per cycle consumed).
//   ISSUE_L1: l1_valid=1, op/addr held stable until l1_ready; on handshake l1_count+1, -> IDLE.
//   ISSUE_SNP: same with snp_*; snp_count+1.
//   DRAIN: wait until busy==0 (checked same cycle of entry) -> STROBE.
//   STROBE: clear_stats (cmd 8) or print_stats (cmd 9) high exactly one cycle -> IDLE.
//   clear_stats also zeroes l1/snp/err counters in that cycle; print does not.
//  Latency: record accepted in cycle N reaches l1_valid/snp_valid at N+2 if FIFO was empty and IDLE.
//  Throughput: one issued request per 2 cycles (handshake + IDLE pop); no back-to-back issue.
//  valid never deasserts before ready; op/addr never change while valid=1 and ready=0.
//  At most one of l1_valid, snp_valid, clear_stats, print_stats high in any cycle.
//  Counters saturate at all-ones; no wrap.
//  Reset mid-handshake: valids drop immediately (async); buffered records are discarded.
// STRUCTURE
//  Package l2_trace_pkg: trace_cmd_e enum (RD_D=0..RWIM=6, CLEAR=8, PRINT=9), l1_op_e, snp_op_e,
//   fsm state enum, helper function is_legal_cmd().
//  One sub-module: trace_fifo (parameterised sync FIFO, width 4+addressSize, async active-low reset).
//  Top holds FSM, output registers, counters.
// TESTING
//  Reset with records buffered -> all outputs 0, trace_ready=1, queued records never issued.
//  Push cmd1 addr 0x1234_5678, l1_ready=1 -> l1_valid at +2 cycles, l1_op=1, l1_addr matches, l1_count=1.
//  Push cmd4 addr 0xDEAD_BEC0, snp_ready held 0 for 5 cycles -> snp_valid/snp_op=1/addr stable 5 cycles, count on 6th.
//  Push 9 records with no ready -> trace_ready=0 after FIFO full (8 + 1 in output reg), issue order preserved.
//  Push cmd9 with busy=1 for 4 cycles -> print_stats single pulse 1 cycle after busy falls; cmd8 zeroes counters.
//  Push cmds 7, 15, 0 -> err_count=2, only cmd0 issued; counters at all-ones stay saturated.

Source files
------------

// File: rtl/l2_trace_pkg.sv
// Shared types for the L2 trace sequencer.
// Trace command codes, request op encodings, FSM states.
package l2_trace_pkg;

    typedef enum logic [3:0] {
        RD_D     = 4'd0,
        WR_D     = 4'd1,
        RD_I     = 4'd2,
        SNP_INV  = 4'd3,
        SNP_RD   = 4'd4,
        SNP_WR   = 4'd5,
        SNP_RWIM = 4'd6,
        CLEAR    = 4'd8,
        PRINT    = 4'd9
    } trace_cmd_e;

    typedef enum logic [1:0] {
        L1_RD_DATA  = 2'd0,
        L1_WR_DATA  = 2'd1,
        L1_RD_INSTR = 2'd2
    } l1_op_e;

    typedef enum logic [1:0] {
        SNOOP_INVAL = 2'd0,
        SNOOP_READ  = 2'd1,
        SNOOP_WRITE = 2'd2,
        SNOOP_RWIM  = 2'd3
    } snp_op_e;

    typedef logic [2:0] fsmState_t;

    localparam fsmState_t stIdle     = 3'd0;
    localparam fsmState_t stIssueL1  = 3'd1;
    localparam fsmState_t stIssueSnp = 3'd2;
    localparam fsmState_t stDrain    = 3'd3;
    localparam fsmState_t stStrobe   = 3'd4;

    function automatic logic is_legal_cmd(input logic [3:0] cmd);
        return (cmd <= SNP_RWIM) || (cmd == CLEAR) || (cmd == PRINT);
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous record FIFO for the trace sequencer.
// Pointers carry one extra wrap bit to tell full from empty.
module trace_fifo #(
    parameter int width = 36,
    parameter int depth = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wrEn,
    input  logic [width-1:0] wrData,
    output logic             full,
    input  logic             rdEn,
    output logic [width-1:0] rdData,
    output logic             empty
);

    localparam int aw = $clog2(depth);

    logic [width-1:0] mem [depth];
    logic [aw:0]      wrPtr;
    logic [aw:0]      rdPtr;

    assign empty  = (wrPtr == rdPtr);
    assign full   = (wrPtr[aw] != rdPtr[aw]) &&
                    (wrPtr[aw-1:0] == rdPtr[aw-1:0]);
    assign rdData = mem[rdPtr[aw-1:0]];

    always_ff @(posedge clk) begin
        if (wrEn && !full) begin
            mem[wrPtr[aw-1:0]] <= wrData;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (wrEn && !full) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (rdEn && !empty) begin
                rdPtr <= rdPtr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/l2_trace_sequencer.sv
// Buffers trace records and issues them in order to the L2 cache
// L1-side or snoop-side port; runs clear/print as stat strobes.
module l2_trace_sequencer
    import l2_trace_pkg::*;
#(
    parameter int addressSize = 32,
    parameter int fifoDepth   = 8,
    parameter int cntWidth    = 32
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   trace_valid,
    output logic                   trace_ready,
    input  logic [3:0]             trace_cmd,
    input  logic [addressSize-1:0] trace_addr,
    output logic                   l1_valid,
    input  logic                   l1_ready,
    output logic [1:0]             l1_op,
    output logic [addressSize-1:0] l1_addr,
    output logic                   snp_valid,
    input  logic                   snp_ready,
    output logic [1:0]             snp_op,
    output logic [addressSize-1:0] snp_addr,
    input  logic                   busy,
    output logic                   clear_stats,
    output logic                   print_stats,
    output logic [cntWidth-1:0]    l1_count,
    output logic [cntWidth-1:0]    snp_count,
    output logic [cntWidth-1:0]    err_count
);

    fsmState_t state;
    logic      isClear;
    logic      fifoFull;
    logic      fifoEmpty;
    logic      pop;

    logic [addressSize+3:0] headRec;
    logic [3:0]             headCmd;
    logic [addressSize-1:0] headAddr;

    assign headCmd     = headRec[addressSize+3:addressSize];
    assign headAddr    = headRec[addressSize-1:0];
    assign trace_ready = !fifoFull;
    assign pop         = (state == stIdle) && !fifoEmpty;

    trace_fifo #(
        .width(addressSize + 4),
        .depth(fifoDepth)
    ) uFifo (
        .clk    (clk),
        .reset_n(reset_n),
        .wrEn   (trace_valid),
        .wrData ({trace_cmd, trace_addr}),
        .full   (fifoFull),
        .rdEn   (pop),
        .rdData (headRec),
        .empty  (fifoEmpty)
    );

    function automatic logic [cntWidth-1:0] satInc(
        input logic [cntWidth-1:0] v
    );
        return (&v) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= stIdle;
            isClear     <= 1'b0;
            l1_valid    <= 1'b0;
            l1_op       <= '0;
            l1_addr     <= '0;
            snp_valid   <= 1'b0;
            snp_op      <= '0;
            snp_addr    <= '0;
            clear_stats <= 1'b0;
            print_stats <= 1'b0;
            l1_count    <= '0;
            snp_count   <= '0;
            err_count   <= '0;
        end else begin
            clear_stats <= 1'b0;
            print_stats <= 1'b0;
            unique case (state)
                stIdle: begin
                    if (!fifoEmpty) begin
                        unique case (1'b1)
                            (headCmd <= RD_I): begin
                                l1_valid <= 1'b1;
                                l1_op    <= headCmd[1:0];
                                l1_addr  <= headAddr;
                                state    <= stIssueL1;
                            end
                            (headCmd >= SNP_INV && headCmd <= SNP_RWIM): begin
                                snp_valid <= 1'b1;
                                // cmd-3 modulo 4 is cmd+1 on the low bits
                                snp_op    <= headCmd[1:0] + 2'd1;
                                snp_addr  <= headAddr;
                                state     <= stIssueSnp;
                            end
                            (headCmd == CLEAR || headCmd == PRINT): begin
                                isClear <= (headCmd == CLEAR);
                                state   <= stDrain;
                            end
                            (!is_legal_cmd(headCmd)): begin
                                err_count <= satInc(err_count);
                            end
                            default: ;
                        endcase
                    end
                end
                stIssueL1: begin
                    if (l1_ready) begin
                        l1_valid <= 1'b0;
                        l1_count <= satInc(l1_count);
                        state    <= stIdle;
                    end
                end
                stIssueSnp: begin
                    if (snp_ready) begin
                        snp_valid <= 1'b0;
                        snp_count <= satInc(snp_count);
                        state     <= stIdle;
                    end
                end
                stDrain: begin
                    if (!busy) begin
                        clear_stats <= isClear;
                        print_stats <= !isClear;
                        if (isClear) begin
                            l1_count  <= '0;
                            snp_count <= '0;
                            err_count <= '0;
                        end
                        state <= stStrobe;
                    end
                end
                stStrobe: begin
                    state <= stIdle;
                end
                default: begin
                    state <= stIdle;
                end
            endcase
        end
    end

endmodule
